sprite_draw_scheduler: RTL and testbench

//  Shares the single VGA framebuffer write port (x, y, colour, plot) among N_REQ sprite requesters.

---
 rtl/asteroids_pkg.sv | 15 +
 rtl/sprite_draw_scheduler_rr_arbiter.sv | 30 +++
 rtl/sprite_draw_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Shared constants and draw-FSM encoding for the asteroids game blocks.
package asteroids_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } draw_state_t;

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    win_idx,
    output logic             valid
);

    int j;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        valid   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!valid && req[IW'(j)]) begin
                valid   = 1'b1;
                winner  = N_REQ'(1) << j;
                win_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares the VGA write port among sprite requesters, scanning one box pixel per clock with clipping.
// Optional build macro SPRITE_ERASE_EN adds req_erase to draw a sprite in background colour.
module sprite_draw_scheduler
    import asteroids_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_x,
    input  logic [7*N_REQ-1:0] req_y,
    input  logic [3*N_REQ-1:0] req_colour,
`ifdef SPRITE_ERASE_EN
    input  logic [N_REQ-1:0]   req_erase,
`endif
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               vga_plot
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] LAST_CX  = 4'(SPRITE_W - 1);
    localparam logic [3:0] LAST_CY  = 4'(SPRITE_H - 1);
    localparam logic [8:0] SCREEN_X = 9'(SCREEN_W);
    localparam logic [7:0] SCREEN_Y = 8'(SCREEN_H);

    draw_state_t state, next_state;
    logic [IW-1:0] ptr, idx;
    logic [7:0]    base_x;
    logic [6:0]    base_y;
    logic [2:0]    base_colour;
    logic [3:0]    cx, cy;
    logic          at_last;

    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]    win_idx;
    logic             win_valid;

    logic [7:0] x_arr [N_REQ];
    logic [6:0] y_arr [N_REQ];
    logic [2:0] c_arr [N_REQ];
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;

    logic [7:0]       pix_base_x;
    logic [6:0]       pix_base_y;
    logic [2:0]       pix_colour;
    logic [3:0]       nxt_cx, nxt_cy;
    logic             nxt_active, nxt_last;
    logic [N_REQ-1:0] nxt_grant;
    logic [IW-1:0]    nxt_done_idx;
    logic [8:0]       sum_x;
    logic [7:0]       sum_y;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .winner  (win_onehot),
        .win_idx (win_idx),
        .valid   (win_valid)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign x_arr[i] = req_x[8*i +: 8];
        assign y_arr[i] = req_y[7*i +: 7];
        assign c_arr[i] = req_colour[3*i +: 3];
    end

    // Erase is folded into the latched colour so the scan itself never sees it.
    always_comb begin
        sel_x = x_arr[win_idx];
        sel_y = y_arr[win_idx];
`ifdef SPRITE_ERASE_EN
        sel_colour = req_erase[win_idx] ? COL_BLACK : c_arr[win_idx];
`else
        sel_colour = c_arr[win_idx];
`endif
    end

    assign at_last = (cx == LAST_CX) && (cy == LAST_CY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            idx         <= '0;
            base_x      <= '0;
            base_y      <= '0;
            base_colour <= '0;
            cx          <= '0;
            cy          <= '0;
        end else begin
            state <= next_state;
            cx    <= nxt_cx;
            cy    <= nxt_cy;
            if (state == S_IDLE && win_valid) begin
                idx         <= win_idx;
                base_x      <= sel_x;
                base_y      <= sel_y;
                base_colour <= sel_colour;
            end
            if (state == S_DRAW && at_last)
                ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (win_valid) next_state = S_DRAW;
            S_DRAW:  if (at_last)   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Computes the pixel shown next cycle; cx/cy always name the pixel currently on the outputs.
    always_comb begin
        pix_base_x   = base_x;
        pix_base_y   = base_y;
        pix_colour   = base_colour;
        nxt_cx       = '0;
        nxt_cy       = '0;
        nxt_active   = 1'b0;
        nxt_grant    = '0;
        nxt_done_idx = idx;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    nxt_active   = 1'b1;
                    nxt_grant    = win_onehot;
                    nxt_done_idx = win_idx;
                    pix_base_x   = sel_x;
                    pix_base_y   = sel_y;
                    pix_colour   = sel_colour;
                end
            end
            S_DRAW: begin
                if (!at_last) begin
                    nxt_active = 1'b1;
                    if (cx == LAST_CX) begin
                        nxt_cy = cy + 4'd1;
                    end else begin
                        nxt_cx = cx + 4'd1;
                        nxt_cy = cy;
                    end
                end
            end
            default: ;
        endcase
        sum_x    = {1'b0, pix_base_x} + {5'b0, nxt_cx};
        sum_y    = {1'b0, pix_base_y} + {4'b0, nxt_cy};
        nxt_last = (nxt_cx == LAST_CX) && (nxt_cy == LAST_CY);
    end

    always_ff @(posedge clk) begin
        if (reset || !nxt_active) begin
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            grant      <= nxt_grant;
            done       <= nxt_last ? (N_REQ'(1) << nxt_done_idx) : '0;
            busy       <= 1'b1;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= pix_colour;
            vga_plot   <= (sum_x < SCREEN_X) && (sum_y < SCREEN_Y);
        end
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed self-checking bench for sprite_draw_scheduler (N_REQ=4, 4x4 sprites); honours SPRITE_ERASE_EN.
module tb_sprite_draw_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_x = '0;
    logic [27:0] req_y = '0;
    logic [11:0] req_colour = '0;
`ifdef SPRITE_ERASE_EN
    logic [3:0]  req_erase = '0;
`endif
    logic [3:0]  grant, done;
    logic        busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int last_grant_cycle = 0;
    logic watch_done1 = 1'b0;
    int done1_count = 0;

    sprite_draw_scheduler #(.N_REQ(4), .SPRITE_W(4), .SPRITE_H(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
`ifdef SPRITE_ERASE_EN
        .req_erase  (req_erase),
`endif
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) if (watch_done1 && done[1]) done1_count <= done1_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input int i, input logic [7:0] x,
                                 input logic [6:0] y, input logic [2:0] c);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[3*i +: 3] = c;
        req                  = r;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Advances to the next negedge, then waits (bounded) for a grant pulse.
    task automatic waitGrant(input string tag, input logic [3:0] exp_g);
        int n;
        n = 0;
        @(negedge clk);
        while (grant == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(grant), 32'(exp_g));
    endtask

    // Called on the grant cycle; walks all 16 pixels then the following idle cycle.
    task automatic drawCheck(input string tag, input logic [3:0] who, input logic [7:0] bx,
                             input logic [6:0] by, input logic [2:0] col, input logic [15:0] mask);
        logic [27:0] exp_v, obs_v;
        for (int p = 0; p < 16; p++) begin
            exp_v = {(p == 0) ? who : 4'b0, (p == 15) ? who : 4'b0, 1'b1,
                     8'(bx + 8'(p % 4)), 7'(by + 7'(p / 4)), col, mask[p]};
            obs_v = {grant, done, busy, vga_x, vga_y, vga_colour, vga_plot};
            checkOutput($sformatf("%s_pix%0d", tag, p), 32'(obs_v), 32'(exp_v));
            @(negedge clk);
        end
        checkOutput({tag, "_idle"}, 32'({busy, vga_plot, grant, done, vga_x, vga_y, vga_colour}), 32'(0));
    endtask

    initial begin
        $display("[TB] start");

        // 1. reset
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 32'({grant, done, busy, vga_x, vga_y, vga_colour, vga_plot}), 32'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_no_grant", 32'({grant, busy, vga_plot}), 32'(0));

        // 2. single sprite fully on screen
        applyStimulus(4'b0001, 0, 8'd10, 7'd20, 3'b100);
        waitGrant("t2_grant", 4'b0001);
        req = 4'b0000;
        drawCheck("t2", 4'b0001, 8'd10, 7'd20, 3'b100, 16'hFFFF);

        // 3. all four held: strict rotation, 17 cycles apart
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(4'b1111, i, 8'(i * 20), 7'd10, 3'(i + 1));
        for (int k = 0; k < 5; k++) begin
            waitGrant($sformatf("t3_grant%0d", k), 4'(1 << (k % 4)));
            checkOutput($sformatf("t3_x%0d", k), 32'(vga_x), 32'((k % 4) * 20));
            if (k > 0)
                checkOutput($sformatf("t3_gap%0d", k), 32'(cycle - last_grant_cycle), 32'd17);
            last_grant_cycle = cycle;
        end
        req = 4'b0000;
        repeat (20) @(negedge clk);
        checkOutput("t3_drained", 32'({busy, grant}), 32'(0));

        // 4. corner clipping
        applyStimulus(4'b0100, 2, 8'd158, 7'd118, 3'b010);
        waitGrant("t4_grant", 4'b0100);
        req = 4'b0000;
        drawCheck("t4", 4'b0100, 8'd158, 7'd118, 3'b010, 16'h0033);

        // 5. reset mid-draw
        applyStimulus(4'b0010, 1, 8'd30, 7'd40, 3'b001);
        waitGrant("t5_grant", 4'b0010);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        checkOutput("t5_pix5", 32'({busy, vga_x, vga_y}), 32'({1'b1, 8'd31, 7'd41}));
        reset = 1'b1;
        watch_done1 = 1'b1;
        @(negedge clk);
        checkOutput("t5_after_reset", 32'({busy, vga_plot, done, grant}), 32'(0));
        reset = 1'b0;
        applyStimulus(4'b0011, 0, 8'd70, 7'd80, 3'b011);
        waitGrant("t5_regrant", 4'b0001);
        req = 4'b0000;
        repeat (18) @(negedge clk);
        checkOutput("t5_no_done1", 32'(done1_count), 32'd0);
        watch_done1 = 1'b0;

`ifdef SPRITE_ERASE_EN
        // 6. erase draws background colour
        req_erase = 4'b1000;
        applyStimulus(4'b1000, 3, 8'd50, 7'd60, 3'b111);
        waitGrant("t6_grant", 4'b1000);
        req = 4'b0000;
        req_erase = 4'b0000;
        drawCheck("t6", 4'b1000, 8'd50, 7'd60, 3'b000, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
